// File: rtl/pulse_scheduler.sv
// Round-robin pulse scheduler: latches rising edges on N request lines and serves them
// one at a time as PULSE_W-cycle pulses with GAP_W guard cycles. Macro DROP_COUNT_EN adds drop_cnt.
module pulse_scheduler #(
  parameter int N       = 4,
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 0,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  en,
  output logic [N-1:0]  pulse_out,
  output logic          busy,
  output logic [IW-1:0] grant_id,
  output logic [N-1:0]  pending
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [7:0]    PW_M1 = 8'(PULSE_W - 1);
  localparam logic [7:0]    GW_M1 = 8'(GAP_W - 1);
  localparam logic [IW:0]   N_W   = (IW + 1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  state_t        state, state_n;
  logic [N-1:0]  en_q, edge_v, grant_mask, pend_n, pulse_n;
  logic [7:0]    cnt, cnt_n;
  logic [IW-1:0] rr_ptr, rr_n, gnt_idx, gid_n;
  logic          do_grant;
  logic [2*N-1:0] pend_dbl;
  logic [N-1:0]  rot;
  logic [IW:0]   first_k, idx_sum;

  assign edge_v = en & ~en_q;
  assign busy   = (state != IDLE);

  // Rotate pending so bit 0 is rr_ptr, take the lowest set bit, then map back.
  always_comb begin
    pend_dbl = {pending, pending} >> rr_ptr;
    rot      = pend_dbl[N-1:0];
    first_k  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) first_k = (IW + 1)'(k);
    end
    idx_sum = {1'b0, rr_ptr} + first_k;
    if (idx_sum >= N_W) idx_sum = idx_sum - N_W;
    gnt_idx = idx_sum[IW-1:0];
    rr_n    = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pulse_n  = pulse_out;
    do_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          do_grant = 1'b1;
          state_n  = PULSE;
        end
      end
      PULSE: begin
        if (cnt == 8'd0) begin
          if (GAP_W > 0) begin
            state_n = GAP;
            cnt_n   = GW_M1;
            pulse_n = '0;
          end else if (|pending) begin
            do_grant = 1'b1;
          end else begin
            state_n = IDLE;
            pulse_n = '0;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) begin
          if (|pending) begin
            do_grant = 1'b1;
            state_n  = PULSE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    grant_mask = do_grant ? (N'(1) << gnt_idx) : '0;
    if (do_grant) begin
      cnt_n   = PW_M1;
      pulse_n = grant_mask;
    end
    // grant_id reads 0 whenever no pulse is on the bus.
    gid_n = (pulse_n == '0) ? '0 : (do_grant ? gnt_idx : grant_id);
    // A same-cycle edge on the granted channel re-arms it.
    pend_n = (pending & ~grant_mask) | edge_v;
  end

  always_ff @(posedge clk) begin
    en_q <= en;
    if (!rst_n) begin
      state     <= IDLE;
      pulse_out <= '0;
      grant_id  <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      pulse_out <= pulse_n;
      grant_id  <= gid_n;
      pending   <= pend_n;
      cnt       <= cnt_n;
      if (do_grant) rr_ptr <= rr_n;
    end
  end

`ifdef DROP_COUNT_EN
  logic [N-1:0] drop_v;
  logic [4:0]   drop_sum;
  logic [16:0]  drop_acc;

  always_comb begin
    drop_v   = edge_v & pending & ~grant_mask;
    drop_sum = '0;
    for (int k = 0; k < N; k++) drop_sum = drop_sum + 5'(drop_v[k]);
    drop_acc = {1'b0, drop_cnt} + 17'(drop_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= drop_acc[16] ? 16'hFFFF : drop_acc[15:0];
  end
`endif

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: three instances (1/0, 3/2 and 4/0 pulse/gap widths)
// driven with hand-computed sequences; drop_cnt is checked when DROP_COUNT_EN is defined.
module tb_pulse_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en_a = '0, en_b = '0, en_c = '0;
  logic [3:0] po_a, po_b, po_c, pend_a, pend_b, pend_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic       busy_a, busy_b, busy_c;
`ifdef DROP_COUNT_EN
  logic [15:0] dc_a, dc_b, dc_c;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_scheduler #(.N(4), .PULSE_W(1), .GAP_W(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .pulse_out(po_a), .busy(busy_a),
    .grant_id(gid_a), .pending(pend_a)
`ifdef DROP_COUNT_EN
    , .drop_cnt(dc_a)
`endif
  );

  pulse_scheduler #(.N(4), .PULSE_W(3), .GAP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .pulse_out(po_b), .busy(busy_b),
    .grant_id(gid_b), .pending(pend_b)
`ifdef DROP_COUNT_EN
    , .drop_cnt(dc_b)
`endif
  );

  pulse_scheduler #(.N(4), .PULSE_W(4), .GAP_W(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .pulse_out(po_c), .busy(busy_c),
    .grant_id(gid_c), .pending(pend_c)
`ifdef DROP_COUNT_EN
    , .drop_cnt(dc_c)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [3:0] exp_b [12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                             4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000};
  logic [3:0] exp_a4 [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};

  initial begin
    int busy_n, ch0_n;

    // Reset state
    do_reset();
    check("rst_pulse", po_a, 4'b0000);
    check("rst_busy", busy_a, 0);
    check("rst_gid", gid_a, 0);
    check("rst_pend", pend_a, 4'b0000);
`ifdef DROP_COUNT_EN
    check("rst_drop", dc_c, 0);
`endif

    // Single request on ch2
    en_a = 4'b0100;
    tick();
    check("t1_pend", pend_a, 4'b0100);
    check("t1_nopulse", po_a, 4'b0000);
    tick();
    check("t1_pulse", po_a, 4'b0100);
    check("t1_gid", gid_a, 2);
    check("t1_busy", busy_a, 1);
    tick();
    check("t1_end", po_a, 4'b0000);
    check("t1_idle", busy_a, 0);
    check("t1_gid0", gid_a, 0);
    en_a = 4'b0000;

    // All four rise together: back-to-back pulses
    do_reset();
    en_a = 4'b1111;
    tick();
    check("t2_pend", pend_a, 4'b1111);
    busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t2_pulse%0d", i), po_a, exp_a4[i]);
      if (busy_a) busy_n++;
    end
    check("t2_busy_cycles", busy_n, 4);
    // rr_ptr wrapped to 0, so ch0 beats ch3
    en_a = 4'b0000;
    tick();
    en_a = 4'b1001;
    tick();
    tick();
    check("t2_wrap_first", po_a, 4'b0001);
    tick();
    check("t2_wrap_second", po_a, 4'b1000);
    check("t2_wrap_gid", gid_a, 3);
    en_a = 4'b0000;

    // Pulse 3 / gap 2 with ch1 and ch3
    do_reset();
    en_b = 4'b1010;
    tick();
    check("t3_pend", pend_b, 4'b1010);
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("t3_pulse%0d", i), po_b, exp_b[i]);
      if (busy_b) busy_n++;
    end
    check("t3_busy_cycles", busy_n, 10);
    en_b = 4'b0000;

    // Fairness: after ch1, ch2 is served before ch0
    do_reset();
    en_a = 4'b0010;
    tick();
    tick();
    check("t4_ch1", po_a, 4'b0010);
    en_a = 4'b0000;
    tick();
    en_a = 4'b0101;
    tick();
    check("t4_pend", pend_a, 4'b0101);
    tick();
    check("t4_first", po_a, 4'b0100);
    check("t4_first_gid", gid_a, 2);
    tick();
    check("t4_second", po_a, 4'b0001);
    check("t4_second_gid", gid_a, 0);
    en_a = 4'b0000;

    // Drops: ch0 re-toggled while pending behind ch1
    do_reset();
    en_c = 4'b0001;
    for (int i = 0; i < 6; i++) tick();
    en_c = 4'b0000;
    tick();
    check("t5_pre_idle", busy_c, 0);
    en_c = 4'b0011;
    tick();
    en_c = 4'b0010;
    tick();
    check("t5_ch1", po_c, 4'b0010);
    en_c = 4'b0011;
    tick();
    en_c = 4'b0010;
    tick();
    en_c = 4'b0011;
    tick();
    check("t5_ch1_last", po_c, 4'b0010);
    en_c = 4'b0010;
    tick();
    check("t5_ch0", po_c, 4'b0001);
    ch0_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (po_c[0]) ch0_n++;
      tick();
    end
    check("t5_ch0_cycles", ch0_n, 4);
    check("t5_pend_clear", pend_c, 4'b0000);
`ifdef DROP_COUNT_EN
    check("t5_drop_cnt", dc_c, 2);
`endif
    en_c = 4'b0000;

    // Level held through reset: no request
    en_a = 4'b0001;
    do_reset();
    tick();
    tick();
    tick();
    check("t6_held_pulse", po_a, 4'b0000);
    check("t6_held_pend", pend_a, 4'b0000);
    en_a = 4'b0000;

    // Reset mid-pulse kills pulse and pending
    en_b = 4'b0000;
    do_reset();
    en_b = 4'b0011;
    tick();
    tick();
    check("t6_mid_pulse", po_b, 4'b0001);
    rst_n = 1'b0;
    tick();
    check("t6_rst_pulse", po_b, 4'b0000);
    check("t6_rst_pend", pend_b, 4'b0000);
    check("t6_rst_busy", busy_b, 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("t6_after_pulse", po_b, 4'b0000);
    check("t6_after_pend", pend_b, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
